// File: rtl/vec_datapath.sv
// vec_datapath: two-stage SIMD datapath (execute -> writeback) with a small
// lane-sliced register file. Build option VEC_DATAPATH_FWD_EN forwards the
// writeback results into the execute operands; without it a read-after-write
// dependency on the instruction in writeback stalls intake for one cycle.
module vec_datapath #(
    parameter  int WIDTH = 4,
    parameter  int LANES = 2,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic                     form,
    input  logic [LANES-1:0]         vec,
    input  logic [AW-1:0]            src_a,
    input  logic [AW-1:0]            src_b,
    input  logic [AW-1:0]            dst1,
    input  logic [AW-1:0]            dst2,
    input  logic [WIDTH-1:0]         imm,
    input  logic [1:0]               write,
    output logic                     out_valid,
    output logic [LANES*WIDTH-1:0]   Y1,
    output logic [LANES*WIDTH-1:0]   Y2,
    output logic [LANES-1:0]         zero
);

    typedef logic [LANES*WIDTH-1:0] vec_t;

    vec_t             regs_q [NREGS];
    vec_t             regs_d [NREGS];
    logic             wb_valid_q, wb_valid_d;
    vec_t             y1_q, y1_d;
    vec_t             y2_q, y2_d;
    logic [LANES-1:0] zero_q, zero_d;
    logic [LANES-1:0] wb_vec_q, wb_vec_d;
    logic [AW-1:0]    wb_dst1_q, wb_dst1_d;
    logic [AW-1:0]    wb_dst2_q, wb_dst2_d;
    logic [1:0]       wb_write_q, wb_write_d;

    vec_t             opa, opb, opb_reg;
    vec_t             alu_y1, alu_y2;
    logic [LANES-1:0] alu_zero;
    logic             hazard;
    logic             accept;

    // Operand fetch: register 0 reads as zero; forwarded build overrides lanes the writeback instruction is about to write
    always_comb begin
        opa     = (src_a == '0) ? '0 : regs_q[src_a];
        opb_reg = (src_b == '0) ? '0 : regs_q[src_b];
`ifdef VEC_DATAPATH_FWD_EN
        for (int l = 0; l < LANES; l++) begin
            if (wb_valid_q && wb_vec_q[l]) begin
                if (wb_write_q[0] && wb_dst1_q != '0 && wb_dst1_q == src_a)
                    opa[l*WIDTH +: WIDTH] = y1_q[l*WIDTH +: WIDTH];
                else if (wb_write_q[1] && wb_dst2_q != '0 && wb_dst2_q == src_a)
                    opa[l*WIDTH +: WIDTH] = y2_q[l*WIDTH +: WIDTH];
                if (wb_write_q[0] && wb_dst1_q != '0 && wb_dst1_q == src_b)
                    opb_reg[l*WIDTH +: WIDTH] = y1_q[l*WIDTH +: WIDTH];
                else if (wb_write_q[1] && wb_dst2_q != '0 && wb_dst2_q == src_b)
                    opb_reg[l*WIDTH +: WIDTH] = y2_q[l*WIDTH +: WIDTH];
            end
        end
`endif
        opb = form ? {LANES{imm}} : opb_reg;
    end

    // Dependency detection: stall only when no forwarding path exists
    always_comb begin
        hazard = 1'b0;
`ifndef VEC_DATAPATH_FWD_EN
        if (wb_valid_q) begin
            if (wb_write_q[0] && wb_dst1_q != '0 &&
                (wb_dst1_q == src_a || (!form && wb_dst1_q == src_b)))
                hazard = 1'b1;
            if (wb_write_q[1] && wb_dst2_q != '0 &&
                (wb_dst2_q == src_a || (!form && wb_dst2_q == src_b)))
                hazard = 1'b1;
        end
`endif
        in_ready = rst_n && !(in_valid && hazard);
        accept   = in_valid && in_ready;
    end

    // Per-lane ALU producing both result words and the per-lane zero flag
    always_comb begin : alu
        logic [WIDTH-1:0]   a, b, r1, r2;
        logic [WIDTH:0]     sum, diff;
        logic [2*WIDTH-1:0] prod;
        int                 shamt;
        alu_y1   = '0;
        alu_y2   = '0;
        alu_zero = '0;
        for (int l = 0; l < LANES; l++) begin
            a     = opa[l*WIDTH +: WIDTH];
            b     = opb[l*WIDTH +: WIDTH];
            sum   = {1'b0, a} + {1'b0, b};
            diff  = {1'b0, a} - {1'b0, b};
            prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            shamt = int'(b) % WIDTH;
            r1    = '0;
            r2    = b;
            case (op)
                3'd0: begin r1 = sum[WIDTH-1:0];  r2 = {{(WIDTH-1){1'b0}}, sum[WIDTH]};  end
                3'd1: begin r1 = diff[WIDTH-1:0]; r2 = {{(WIDTH-1){1'b0}}, diff[WIDTH]}; end
                3'd2: r1 = a & b;
                3'd3: r1 = a | b;
                3'd4: r1 = a ^ b;
                3'd5: r1 = a << shamt;
                3'd6: r1 = a >> shamt;
                default: begin r1 = prod[WIDTH-1:0]; r2 = prod[2*WIDTH-1:WIDTH]; end
            endcase
            if (vec[l]) begin
                alu_y1[l*WIDTH +: WIDTH] = r1;
                alu_y2[l*WIDTH +: WIDTH] = r2;
                alu_zero[l]              = (r1 == '0);
            end
        end
    end

    // Writeback stage capture: results and write controls latch only on acceptance
    always_comb begin
        wb_valid_d = accept;
        y1_d       = y1_q;
        y2_d       = y2_q;
        zero_d     = zero_q;
        wb_vec_d   = wb_vec_q;
        wb_dst1_d  = wb_dst1_q;
        wb_dst2_d  = wb_dst2_q;
        wb_write_d = wb_write_q;
        if (accept) begin
            y1_d       = alu_y1;
            y2_d       = alu_y2;
            zero_d     = alu_zero;
            wb_vec_d   = vec;
            wb_dst1_d  = dst1;
            wb_dst2_d  = dst2;
            wb_write_d = write;
        end
    end

    // Register file update: Y2 applied first so Y1 wins when both target the same register
    always_comb begin
        regs_d = regs_q;
        if (wb_valid_q) begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_vec_q[l]) begin
                    if (wb_write_q[1] && wb_dst2_q != '0)
                        regs_d[wb_dst2_q][l*WIDTH +: WIDTH] = y2_q[l*WIDTH +: WIDTH];
                    if (wb_write_q[0] && wb_dst1_q != '0)
                        regs_d[wb_dst1_q][l*WIDTH +: WIDTH] = y1_q[l*WIDTH +: WIDTH];
                end
            end
        end
    end

    // State registers with synchronous active-low reset; reset drops any pending writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            wb_valid_q <= 1'b0;
            y1_q       <= '0;
            y2_q       <= '0;
            zero_q     <= '0;
            wb_vec_q   <= '0;
            wb_dst1_q  <= '0;
            wb_dst2_q  <= '0;
            wb_write_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
            wb_valid_q <= wb_valid_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            zero_q     <= zero_d;
            wb_vec_q   <= wb_vec_d;
            wb_dst1_q  <= wb_dst1_d;
            wb_dst2_q  <= wb_dst2_d;
            wb_write_q <= wb_write_d;
        end
    end

    assign out_valid = wb_valid_q;
    assign Y1        = y1_q;
    assign Y2        = y2_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_vec_datapath.sv
// tb_vec_datapath: directed literal checks plus randomized traffic against an
// in-order architectural model of vec_datapath (WIDTH=4, LANES=2, NREGS=8).
module tb_vec_datapath;
    localparam int WIDTH = 4;
    localparam int LANES = 2;
    localparam int NREGS = 8;
    localparam int M     = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       form = 1'b0;
    logic [2:0] op = '0;
    logic [1:0] vec = '0;
    logic [1:0] write = '0;
    logic [2:0] src_a = '0, src_b = '0, dst1 = '0, dst2 = '0;
    logic [3:0] imm = '0;
    logic       in_ready, out_valid;
    logic [7:0] Y1, Y2;
    logic [1:0] zero;

    vec_datapath #(.WIDTH(WIDTH), .LANES(LANES), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .form(form), .vec(vec), .src_a(src_a), .src_b(src_b),
        .dst1(dst1), .dst2(dst2), .imm(imm), .write(write),
        .out_valid(out_valid), .Y1(Y1), .Y2(Y2), .zero(zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural model state: committed registers plus the one result in flight
    int         mregs [NREGS][LANES];
    bit         pend_valid = 1'b0;
    int         pend_y1 [LANES];
    int         pend_y2 [LANES];
    logic [1:0] pend_vec = '0, pend_write = '0;
    logic [2:0] pend_d1 = '0, pend_d2 = '0;
    bit         show_reset = 1'b0;
    bit         started = 1'b0;
    bit         last_accept = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function bit reads_reg(input logic [2:0] r);
        return (r != 0) && (src_a == r || (!form && src_b == r));
    endfunction

    function bit raw_hazard();
        return pend_valid && ((pend_write[0] && reads_reg(pend_d1)) ||
                              (pend_write[1] && reads_reg(pend_d2)));
    endfunction

    function bit exp_ready();
`ifdef VEC_DATAPATH_FWD_EN
        return rst_n;
`else
        return rst_n && !(in_valid && raw_hazard());
`endif
    endfunction

    // Model: at each edge retire the in-flight result, then execute the accepted instruction in program order
    initial begin
        for (int r = 0; r < NREGS; r++)
            for (int l = 0; l < LANES; l++) mregs[r][l] = 0;
        for (int l = 0; l < LANES; l++) begin pend_y1[l] = 0; pend_y2[l] = 0; end
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int r = 0; r < NREGS; r++)
                    for (int l = 0; l < LANES; l++) mregs[r][l] = 0;
                for (int l = 0; l < LANES; l++) begin pend_y1[l] = 0; pend_y2[l] = 0; end
                pend_valid  = 1'b0;
                show_reset  = 1'b1;
                started     = 1'b1;
                last_accept = 1'b0;
            end else begin
                bit acc;
                acc = in_valid && exp_ready();
                if (pend_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (pend_vec[l]) begin
                            if (pend_write[1] && pend_d2 != 0) mregs[pend_d2][l] = pend_y2[l];
                            if (pend_write[0] && pend_d1 != 0) mregs[pend_d1][l] = pend_y1[l];
                        end
                    end
                end
                if (acc) begin
                    for (int l = 0; l < LANES; l++) begin
                        int a, b, y1, y2;
                        a = mregs[src_a][l];
                        b = form ? int'(imm) : mregs[src_b][l];
                        y2 = b;
                        case (op)
                            3'd0: begin y1 = (a + b) % M; y2 = (a + b) / M; end
                            3'd1: begin y1 = (a - b + M) % M; y2 = (a < b) ? 1 : 0; end
                            3'd2: y1 = a & b;
                            3'd3: y1 = a | b;
                            3'd4: y1 = a ^ b;
                            3'd5: y1 = (a << (b % WIDTH)) % M;
                            3'd6: y1 = a >> (b % WIDTH);
                            default: begin y1 = (a * b) % M; y2 = (a * b) / M; end
                        endcase
                        pend_y1[l] = vec[l] ? y1 : 0;
                        pend_y2[l] = vec[l] ? y2 : 0;
                    end
                    pend_vec   = vec;
                    pend_write = write;
                    pend_d1    = dst1;
                    pend_d2    = dst2;
                end
                pend_valid  = acc;
                show_reset  = 1'b0;
                last_accept = acc;
            end
        end
    end

    // Compare process: every cycle, mid-period, check handshake and any meaningful outputs
    always @(negedge clk) begin
        if (started) begin
            logic [7:0] e1, e2;
            logic [1:0] ez;
            for (int l = 0; l < LANES; l++) begin
                e1[l*4 +: 4] = pend_y1[l][3:0];
                e2[l*4 +: 4] = pend_y2[l][3:0];
                ez[l]        = pend_valid && pend_vec[l] && (pend_y1[l] == 0);
            end
            check_output("in_ready", in_ready, exp_ready());
            check_output("out_valid", out_valid, pend_valid);
            if (pend_valid || show_reset) begin
                check_output("Y1", Y1, e1);
                check_output("Y2", Y2, e2);
                check_output("zero", zero, ez);
            end
        end
    end

    // Drive one instruction and hold it until accepted; reports cycles spent stalled
    task automatic apply_stimulus(input logic [2:0] o, input logic f, input logic [1:0] v,
                                  input logic [2:0] sa, input logic [2:0] sb,
                                  input logic [2:0] d1, input logic [2:0] d2,
                                  input logic [3:0] im, input logic [1:0] wr,
                                  output int stalls);
        op = o; form = f; vec = v; src_a = sa; src_b = sb;
        dst1 = d1; dst2 = d2; imm = im; write = wr; in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(posedge clk);
            #1;
            if (last_accept) break;
            stalls++;
            if (stalls > 5) begin
                check_output("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    int st;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready", in_ready, 1'b0);
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_Y1", Y1, 8'h00);
        rst_n = 1'b1;

        // r1 = {8,3}, then reset must wipe it
        apply_stimulus(3'd3, 1'b1, 2'b01, 3'd0, 3'd0, 3'd1, 3'd0, 4'h3, 2'b01, st);
        apply_stimulus(3'd3, 1'b1, 2'b10, 3'd0, 3'd0, 3'd1, 3'd0, 4'h8, 2'b01, st);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_output("rst2_out_valid_a", out_valid, 1'b0);
        @(posedge clk); #1;
        check_output("rst2_out_valid_b", out_valid, 1'b0);
        rst_n = 1'b1;
        apply_stimulus(3'd0, 1'b0, 2'b11, 3'd1, 3'd0, 3'd0, 3'd0, 4'h0, 2'b00, st);
        check_output("after_rst_add_Y1", Y1, 8'h00);

        // ADD with immediate and carry out of lane 1
        apply_stimulus(3'd3, 1'b1, 2'b01, 3'd0, 3'd0, 3'd1, 3'd0, 4'h3, 2'b01, st);
        apply_stimulus(3'd3, 1'b1, 2'b10, 3'd0, 3'd0, 3'd1, 3'd0, 4'h8, 2'b01, st);
        apply_stimulus(3'd0, 1'b1, 2'b11, 3'd1, 3'd0, 3'd0, 3'd0, 4'h9, 2'b00, st);
        check_output("add_imm_Y1", Y1, 8'h1C);
        check_output("add_imm_Y2", Y2, 8'h10);
        check_output("add_imm_zero", zero, 2'b00);
        check_output("add_imm_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        check_output("add_imm_pulse_end", out_valid, 1'b0);

        // Back-to-back dependency through r2
        apply_stimulus(3'd0, 1'b1, 2'b11, 3'd1, 3'd0, 3'd2, 3'd0, 4'h1, 2'b01, st);
        check_output("dep_add_Y1", Y1, 8'h94);
        apply_stimulus(3'd1, 1'b1, 2'b11, 3'd2, 3'd0, 3'd0, 3'd0, 4'h2, 2'b00, st);
        check_output("dep_sub_Y1", Y1, 8'h72);
`ifdef VEC_DATAPATH_FWD_EN
        check_output("dep_stall_cycles", st, 0);
`else
        check_output("dep_stall_cycles", st, 1);
`endif

        // Masked XOR leaves disabled lane untouched
        apply_stimulus(3'd3, 1'b1, 2'b11, 3'd0, 3'd0, 3'd3, 3'd0, 4'h5, 2'b01, st);
        apply_stimulus(3'd4, 1'b1, 2'b01, 3'd3, 3'd0, 3'd3, 3'd0, 4'h5, 2'b01, st);
        check_output("xor_mask_Y1", Y1, 8'h00);
        check_output("xor_mask_zero", zero, 2'b01);
        apply_stimulus(3'd3, 1'b1, 2'b11, 3'd3, 3'd0, 3'd0, 3'd0, 4'h0, 2'b00, st);
        check_output("xor_mask_r3", Y1, 8'h50);

        // MUL with both results aimed at the same register, then at r0
        apply_stimulus(3'd3, 1'b1, 2'b11, 3'd0, 3'd0, 3'd4, 3'd0, 4'hF, 2'b01, st);
        apply_stimulus(3'd7, 1'b1, 2'b11, 3'd4, 3'd0, 3'd5, 3'd5, 4'hF, 2'b11, st);
        check_output("mul_Y1", Y1, 8'h11);
        check_output("mul_Y2", Y2, 8'hEE);
        apply_stimulus(3'd3, 1'b1, 2'b11, 3'd5, 3'd0, 3'd0, 3'd0, 4'h0, 2'b00, st);
        check_output("mul_r5", Y1, 8'h11);
        apply_stimulus(3'd7, 1'b1, 2'b11, 3'd4, 3'd0, 3'd0, 3'd0, 4'hF, 2'b11, st);
        apply_stimulus(3'd3, 1'b0, 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, 2'b00, st);
        check_output("mul_r0", Y1, 8'h00);

        // Randomized traffic, biased toward a few registers to provoke dependencies
        repeat (3000) begin
            logic [2:0] hi;
            hi       = ($urandom_range(1) == 0) ? 3'd3 : 3'd7;
            in_valid = ($urandom_range(3) != 0);
            op       = 3'($urandom_range(7));
            form     = 1'($urandom_range(1));
            vec      = 2'($urandom_range(3));
            src_a    = 3'($urandom_range(hi));
            src_b    = 3'($urandom_range(hi));
            dst1     = 3'($urandom_range(hi));
            dst2     = 3'($urandom_range(hi));
            imm      = 4'($urandom_range(15));
            write    = 2'($urandom_range(3));
            rst_n    = ($urandom_range(99) != 0);
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
